// File: rtl/ps2_pkg.sv
// Shared scan-code constants, FSM encodings and the arrow-key mask helper
// for the PS/2 arrow-key decoder.
package ps2_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] SC_EXT   = 8'hE0;
  localparam logic [BYTE_W-1:0] SC_BRK   = 8'hF0;
  localparam logic [BYTE_W-1:0] SC_UP    = 8'h75;
  localparam logic [BYTE_W-1:0] SC_DOWN  = 8'h72;
  localparam logic [BYTE_W-1:0] SC_LEFT  = 8'h6B;
  localparam logic [BYTE_W-1:0] SC_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    DEC_BASE,
    DEC_EXT,
    DEC_BRK,
    DEC_EXT_BRK
  } dec_state_e;

  typedef struct packed {
    logic right;
    logic left;
    logic down;
    logic up;
  } move_t;

  // One-hot move flag for an arrow scan code; zero for anything else.
  function automatic move_t arrow_mask(input logic [BYTE_W-1:0] code);
    move_t m;
    m = '0;
    case (code)
      SC_UP:    m.up    = 1'b1;
      SC_DOWN:  m.down  = 1'b1;
      SC_LEFT:  m.left  = 1'b1;
      SC_RIGHT: m.right = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizer, falling-edge detect, frame FSM with
// odd-parity check, and an inter-edge watchdog that abandons partial frames.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic [BYTE_W-1:0] rx_byte,
  output logic              byte_valid,
  output logic              frame_err
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic [SYNC_STAGES:0]   clk_chain, data_chain;
  logic                   clk_prev;
  logic                   fall, data_bit;

  rx_state_e         state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [BYTE_W-1:0] byte_d;
  logic              bv_d, fe_d;
  logic              timeout;

  assign clk_chain  = {clk_sync, ps2_clk};
  assign data_chain = {data_sync, ps2_data};
  assign fall       = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign data_bit   = data_sync[SYNC_STAGES-1];
  assign timeout    = (state_q != RX_IDLE) && (wd_q == WD_W'(TIMEOUT_CYCLES));

  // Synchronizer chains idle high so reset never fakes a falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= clk_chain[SYNC_STAGES-1:0];
      data_sync <= data_chain[SYNC_STAGES-1:0];
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RX_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      wd_q       <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      wd_q       <= wd_d;
      rx_byte    <= byte_d;
      byte_valid <= bv_d;
      frame_err  <= fe_d;
    end
  end

  // Timeout wins over a coincident edge; the edge still clears the watchdog.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    byte_d  = rx_byte;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
    if (fall)                               wd_d = '0;
    else if (wd_q == WD_W'(TIMEOUT_CYCLES)) wd_d = wd_q;
    else                                    wd_d = wd_q + WD_W'(1);

    if (timeout) begin
      state_d = RX_IDLE;
      fe_d    = 1'b1;
    end else if (fall) begin
      case (state_q)
        RX_IDLE: begin
          if (!data_bit) begin
            state_d = RX_DATA;
            cnt_d   = '0;
          end else begin
            fe_d = 1'b1;
          end
        end
        RX_DATA: begin
          shift_d = {data_bit, shift_q[BYTE_W-1:1]};
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          par_d   = data_bit;
          state_d = RX_STOP;
        end
        RX_STOP: begin
          if (data_bit && (^{shift_q, par_q})) begin
            bv_d   = 1'b1;
            byte_d = shift_q;
          end else begin
            fe_d = 1'b1;
          end
          state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ps2_arrow_decoder.sv
// PS/2 keyboard arrow-key decoder: tracks E0/F0 prefixes on received bytes
// and holds one level per extended arrow key while it is pressed.
module ps2_arrow_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 20000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic              move_up,
  output logic              move_down,
  output logic              move_left,
  output logic              move_right,
  output logic [BYTE_W-1:0] scan_code,
  output logic              byte_valid,
  output logic              frame_err
);

  dec_state_e dec_q, dec_d;
  move_t      move_q, move_d;

  ps2_rx #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (scan_code),
    .byte_valid (byte_valid),
    .frame_err  (frame_err)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_q  <= DEC_BASE;
      move_q <= '0;
    end else begin
      dec_q  <= dec_d;
      move_q <= move_d;
    end
  end

  // Only extended codes touch the move levels; keypad arrows fall through BRK/BASE.
  always_comb begin
    dec_d  = dec_q;
    move_d = move_q;
    if (frame_err) begin
      dec_d = DEC_BASE;
    end else if (byte_valid) begin
      case (dec_q)
        DEC_BASE: begin
          if (scan_code == SC_EXT)      dec_d = DEC_EXT;
          else if (scan_code == SC_BRK) dec_d = DEC_BRK;
        end
        DEC_EXT: begin
          if (scan_code == SC_BRK)      dec_d = DEC_EXT_BRK;
          else if (scan_code != SC_EXT) begin
            move_d = move_t'(move_q | arrow_mask(scan_code));
            dec_d  = DEC_BASE;
          end
        end
        DEC_BRK: dec_d = DEC_BASE;
        DEC_EXT_BRK: begin
          move_d = move_t'(move_q & ~arrow_mask(scan_code));
          dec_d  = DEC_BASE;
        end
        default: dec_d = DEC_BASE;
      endcase
    end
  end

  assign move_up    = move_q.up;
  assign move_down  = move_q.down;
  assign move_left  = move_q.left;
  assign move_right = move_q.right;

endmodule

// File: doc/ps2_arrow_decoder.md
PS2_ARROW_DECODER -- requirements
Module: ps2_arrow_decoder

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 20000, idle clk cycles after which a partial PS/2 frame is abandoned (200 us at 100 MHz).
REQ-002 Parameter: SYNC_STAGES, default 2, synchronizer depth on ps2_clk and ps2_data.
REQ-003 clk  input  1  100 MHz system clock; sole clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ps2_clk  input  1  PS/2 device clock; asynchronous; idles high.
REQ-006 ps2_data  input  1  PS/2 device data; asynchronous; idles high.
REQ-007 move_up / move_down / move_left / move_right  output  1 each  registered levels; high while the matching arrow key is held.
REQ-008 scan_code  output  8  last correctly received byte; held until the next one.
REQ-009 byte_valid  output  1  one-cycle pulse; scan_code updated this cycle.
REQ-010 frame_err  output  1  one-cycle pulse on parity, start, stop or timeout failure.

Function
REQ-011 ps2_clk and ps2_data pass through SYNC_STAGES flops; a falling edge is synchronized previous=1, current=0; ps2_data is sampled in that same cycle.
REQ-012 Receiver FSM states IDLE, DATA, PARITY, STOP; frame = start 0, 8 data bits LSB first, odd parity, stop 1.
REQ-013 IDLE: an edge sampling data=0 enters DATA with bit count 0; an edge sampling data=1 stays in IDLE and pulses frame_err.
REQ-014 DATA: 8 edges shift bits in LSB first, then PARITY; PARITY latches one bit, then STOP.
REQ-015 STOP edge: if stop=1 and the ones count over data+parity is odd, byte_valid pulses and scan_code loads next cycle; otherwise frame_err pulses; the FSM returns to IDLE either way.
REQ-016 Watchdog counter clears on each falling edge; in any non-IDLE state reaching TIMEOUT_CYCLES forces IDLE and pulses frame_err; the counter saturates, no wrap.
REQ-017 Decoder FSM states BASE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0), advanced only on byte_valid.
REQ-018 BASE: E0->EXT, F0->BRK, other->BASE. EXT: F0->EXT_BRK, E0->EXT, other->make code then BASE. BRK/EXT_BRK: any byte->break code then BASE.
REQ-019 Extended make sets, extended break clears: 75=move_up, 72=move_down, 6B=move_left, 74=move_right; non-extended 75/72/6B/74 (keypad) are ignored.
REQ-020 Outputs update one cycle after byte_valid, i.e. two cycles after the stop-bit edge is sampled.
REQ-021 Typematic repeat (repeated E0 make) re-sets an already-set level with no glitch.
REQ-022 Opposite keys held together (up+down, left+right) both assert; arbitration belongs downstream.
REQ-023 frame_err also returns the decoder to BASE; move levels are unchanged.
REQ-024 byte_valid and frame_err never assert in the same cycle.

Reset
REQ-025 Reset forces receiver IDLE, decoder BASE, watchdog 0, synchronizer flops 1, all move_* 0, scan_code 8'h00, byte_valid 0, frame_err 0.
REQ-026 Reset mid-frame discards partial bits; the first frame after release decodes normally.

Structure
REQ-027 Shared package ps2_pkg holds scan-code constants (E0, F0, 75, 72, 6B, 74) and both FSM state encodings.
REQ-028 Sub-module ps2_rx holds the synchronizer, edge detect, receiver FSM and watchdog, and exports byte/byte_valid/frame_err; the top holds the decoder FSM and move registers.

Verification
REQ-029 Frames E0, 75 at 12.5 kHz -> move_up=1 two cycles after the second stop edge; then E0, F0, 75 -> move_up=0; other moves stay 0.
REQ-030 Bare 6B (no E0) -> byte_valid pulse, scan_code=8'h6B, move_left stays 0.
REQ-031 Byte 74 sent with even parity -> frame_err one cycle, no byte_valid; then E0, 74 -> move_right=1.
REQ-032 Five bits of a frame, then idle 25000 cycles -> frame_err at cycle 20000; next full frame E0, 72 -> move_down=1.
REQ-033 E0 6B, then E0 74 held, then E0 F0 6B -> move_left 1 then 0; move_right stays 1 throughout.
REQ-034 reset asserted after 5 bits of the E0 frame, released, then E0, 75 sent -> all outputs 0 during reset; move_up=1 after the stop edge.
